// File: rtl/maze_pkg.sv
// Shared constants for the maze wall-map ROM: address layout, requester
// indices and response-tag sizing.
package maze_pkg;

  localparam int ADDR_W     = 12;
  localparam int ROOM_Y_LSB = 9;
  localparam int ROOM_X_LSB = 6;
  localparam int ROW_LSB    = 3;
  localparam int COL_LSB    = 0;

  localparam int MAZE_N_REQ = 4;
  localparam int REQ_PLAYER = 0;
  localparam int REQ_ENEMY0 = 1;
  localparam int REQ_ENEMY1 = 2;
  localparam int REQ_LOADER = 3;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Tag is {is_render, index, valid}.
  function automatic int tag_w(input int n);
    return idx_w(n) + 2;
  endfunction

  localparam int TAG_W = tag_w(MAZE_N_REQ);

endpackage

// File: rtl/maze_query_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or above ptr,
// wrapping modulo N.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     elig,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     win,
  output logic             any_valid
);

  int best;

  function automatic int rr_dist(input int i, input int p);
    return (i - p + N) % N;
  endfunction

  always_comb begin
    win  = '0;
    best = N;
    for (int i = 0; i < N; i++) begin
      if (elig[i] && (rr_dist(i, int'(ptr)) < best)) begin
        best   = rr_dist(i, int'(ptr));
        win    = '0;
        win[i] = 1'b1;
      end
    end
  end

  assign any_valid = |elig;

endmodule

// File: rtl/maze_query_arbiter.sv
// Shares the single maze-ROM read port between the renderer (fixed priority)
// and N game requesters (round-robin), with a starvation-forced game slot.
module maze_query_arbiter #(
  parameter int N_REQ      = maze_pkg::MAZE_N_REQ,
  parameter int ADDR_W     = maze_pkg::ADDR_W,
  parameter int ROM_LAT    = 1,
  parameter int STARVE_MAX = 64
) (
  input  logic                    CLOCK_25,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic                    rsp_wall,
  input  logic                    render_req,
  input  logic [ADDR_W-1:0]       render_addr,
  output logic                    render_valid,
  output logic                    render_wall,
  output logic                    render_stall,
  output logic                    rom_en,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic                    rom_data
);
  import maze_pkg::*;

  localparam int IDX_W = idx_w(N_REQ);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic             is_render;
    logic [IDX_W-1:0] index;
    logic             valid;
  } tag_t;

  logic [IDX_W-1:0]  rr_ptr;
  logic [CNT_W-1:0]  starve_cnt;
  logic [N_REQ-1:0]  elig, win_oh;
  logic              any_elig, forced, render_win, game_win;
  logic [IDX_W-1:0]  win_idx, ptr_next;
  logic [ADDR_W-1:0] game_addr, win_addr;
  tag_t              issue_tag, tag_out;
  tag_t [ROM_LAT:0]  tag_pipe;

  // A requester granted this cycle is still holding req; mask it.
  assign elig = req & ~gnt;

  rr_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_pick (
    .elig      (elig),
    .ptr       (rr_ptr),
    .win       (win_oh),
    .any_valid (any_elig)
  );

  assign forced     = (starve_cnt == CNT_W'(STARVE_MAX)) && any_elig;
  assign render_win = render_req && !forced;
  assign game_win   = !render_win && any_elig;

  always_comb begin
    win_idx   = '0;
    game_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_oh[i]) begin
        win_idx   = IDX_W'(i);
        game_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign win_addr = render_win ? render_addr : game_addr;
  assign ptr_next = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);

  assign issue_tag.is_render = render_win;
  assign issue_tag.index     = render_win ? '0 : win_idx;
  assign issue_tag.valid     = render_win || game_win;
  assign tag_out             = tag_pipe[ROM_LAT];

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      rom_en       <= 1'b0;
      rom_addr     <= '0;
      gnt          <= '0;
      render_stall <= 1'b0;
      rr_ptr       <= '0;
      starve_cnt   <= '0;
      tag_pipe     <= '0;
      rsp_valid    <= '0;
      rsp_wall     <= 1'b0;
      render_valid <= 1'b0;
      render_wall  <= 1'b0;
    end else begin
      rom_en       <= issue_tag.valid;
      if (issue_tag.valid) rom_addr <= win_addr;
      gnt          <= game_win ? win_oh : '0;
      render_stall <= forced && render_req;
      if (game_win) rr_ptr <= ptr_next;

      if (game_win || !any_elig)
        starve_cnt <= '0;
      else if (starve_cnt != CNT_W'(STARVE_MAX))
        starve_cnt <= starve_cnt + CNT_W'(1);

      // Tag rides alongside the read; stage ROM_LAT lines up with rom_data.
      tag_pipe[0] <= issue_tag;
      for (int k = 1; k <= ROM_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];

      render_valid <= tag_out.valid && tag_out.is_render;
      rsp_valid    <= (tag_out.valid && !tag_out.is_render) ?
                      (N_REQ'(1) << tag_out.index) : '0;
      if (tag_out.valid && tag_out.is_render)  render_wall <= rom_data;
      if (tag_out.valid && !tag_out.is_render) rsp_wall    <= rom_data;
    end
  end

endmodule

// File: tb/tb_maze_query_arbiter.sv
// Scoreboard bench for maze_query_arbiter: per-cycle arbitration model plus
// an in-order response queue checked by an independent monitor.
module tb_maze_query_arbiter;

  localparam int NR   = 4;
  localparam int AW   = 12;
  localparam int LAT  = 2;
  localparam int SMAX = 64;

  logic             CLOCK_25 = 1'b0;
  logic             reset;
  logic [NR-1:0]    req;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]    gnt, rsp_valid;
  logic             rsp_wall, render_req, render_valid, render_wall, render_stall;
  logic [AW-1:0]    render_addr, rom_addr;
  logic             rom_en, rom_data;

  always #20 CLOCK_25 = ~CLOCK_25;

  maze_query_arbiter #(.N_REQ(NR), .ADDR_W(AW), .ROM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .CLOCK_25(CLOCK_25), .reset(reset), .req(req), .req_addr(req_addr), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_wall(rsp_wall), .render_req(render_req),
    .render_addr(render_addr), .render_valid(render_valid), .render_wall(render_wall),
    .render_stall(render_stall), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data)
  );

  // Behavioural ROM: data is valid LAT cycles after rom_en.
  bit            rom_mem [4096];
  logic [AW-1:0] rom_pipe [LAT];
  always @(posedge CLOCK_25) begin
    rom_pipe[0] <= rom_addr;
    for (int k = 1; k < LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
  end
  assign rom_data = rom_mem[rom_pipe[LAT-1]];

  int cyc = 0;
  always @(posedge CLOCK_25) cyc <= cyc + 1;

  typedef struct {
    bit is_r;
    int idx;
    bit wall;
    int due;
  } exp_t;
  exp_t sbq[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state.
  int            m_ptr, m_starve;
  logic [NR-1:0] m_gnt, last_g;
  bit            m_en, m_stall;
  logic [AW-1:0] m_addr;

  // Requester agents and stimulus knobs.
  logic [NR-1:0] a_req;
  logic [AW-1:0] a_addr [NR];
  bit            nr_req;
  logic [AW-1:0] nr_addr;
  int            mode, p_render, p_req;
  bit            rec_on;
  int            g_log[$];
  bit            mon_on;

  task automatic model_step();
    logic [NR-1:0] elig, ng;
    bit forced;
    int w;
    elig   = req & ~m_gnt;
    forced = (m_starve == SMAX) && (elig != 0);
    ng     = '0;
    m_en   = 0;
    m_stall = forced && render_req;
    if (render_req && !forced) begin
      m_en   = 1;
      m_addr = render_addr;
      sbq.push_back('{1'b1, 0, rom_mem[render_addr], cyc + LAT + 2});
      m_starve = (elig != 0) ? ((m_starve + 1 > SMAX) ? SMAX : m_starve + 1) : 0;
    end else if (elig != 0) begin
      w = -1;
      for (int k = 0; k < NR; k++)
        if (w < 0 && elig[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
      ng[w]    = 1'b1;
      m_en     = 1;
      m_addr   = a_addr[w];
      sbq.push_back('{1'b0, w, rom_mem[a_addr[w]], cyc + LAT + 2});
      m_ptr    = (w + 1) % NR;
      m_starve = 0;
    end else begin
      m_starve = 0;
    end
    last_g = m_gnt;
    m_gnt  = ng;
  endtask

  task automatic step();
    @(negedge CLOCK_25);
    check("gnt", gnt, m_gnt);
    check("rom_en", rom_en, m_en);
    if (m_en) check("rom_addr", rom_addr, m_addr);
    check("render_stall", render_stall, m_stall);
    if (rec_on) for (int i = 0; i < NR; i++) if (gnt[i]) g_log.push_back(i);
    for (int i = 0; i < NR; i++) begin
      if (last_g[i]) begin
        a_req[i] = 1'b0;
        if (mode == 1 && $urandom_range(99) < p_req) begin
          a_req[i]  = 1'b1;
          a_addr[i] = AW'($urandom_range(4095));
        end
      end else if (!m_gnt[i] && mode == 1) begin
        if (a_req[i]) begin
          if ($urandom_range(99) < 3) a_req[i] = 1'b0;
        end else if ($urandom_range(99) < p_req) begin
          a_req[i]  = 1'b1;
          a_addr[i] = AW'($urandom_range(4095));
        end
      end
    end
    if (mode == 1) begin
      nr_req  = ($urandom_range(99) < p_render);
      nr_addr = AW'($urandom_range(4095));
    end
    render_req  = nr_req;
    render_addr = nr_addr;
    req         = a_req;
    for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = a_addr[i];
    model_step();
  endtask

  task automatic do_reset();
    @(negedge CLOCK_25);
    reset = 1'b1;
    nr_req = 0; render_req = 1'b0; a_req = '0; req = '0;
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_wall", rsp_wall, 0);
    check("rst_render_valid", render_valid, 0);
    check("rst_render_wall", render_wall, 0);
    check("rst_render_stall", render_stall, 0);
    check("rst_rom_en", rom_en, 0);
    check("rst_rom_addr", rom_addr, 0);
    sbq.delete();
    m_ptr = 0; m_starve = 0; m_gnt = '0; last_g = '0; m_en = 0; m_stall = 0;
    repeat (2) @(negedge CLOCK_25);
    reset = 1'b0;
  endtask

  // Renderer held high with requester 0 pending: grant must land 66 steps in.
  task automatic starve_run(input string name);
    int s_at;
    s_at = -1;
    nr_req = 1; nr_addr = 12'h3C7;
    a_req[0] = 1'b1; a_addr[0] = 12'h051;
    for (int s = 1; s <= 80; s++) begin
      step();
      if (gnt[0] && s_at < 0) begin
        s_at = s;
        check({name, "_stall_with_gnt"}, render_stall, 1);
      end
    end
    check({name, "_latency"}, s_at, 66);
    nr_req = 0;
    repeat (6) step();
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge CLOCK_25) begin
    if (!reset && mon_on) begin
      if (render_valid || rsp_valid != 0) begin
        exp_t e;
        check("rsp_onehot", 32'(render_valid) + $countones(rsp_valid), 1);
        if (sbq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rsp_unexpected: got render_valid=%0b rsp_valid=%0h expected none (cycle %0d)",
                   render_valid, rsp_valid, cyc);
        end else begin
          e = sbq.pop_front();
          check("rsp_kind", render_valid, e.is_r);
          if (!e.is_r) check("rsp_idx", rsp_valid, NR'(1) << e.idx);
          check("rsp_wall", e.is_r ? render_wall : rsp_wall, e.wall);
          check("rsp_latency", cyc, e.due);
        end
      end else if (sbq.size() > 0 && sbq[0].due < cyc) begin
        e_missing: begin
          exp_t m;
          m = sbq.pop_front();
          n_tests++; n_fail++;
          $display("FAIL rsp_missing: got nothing expected response due cycle %0d (cycle %0d)", m.due, cyc);
        end
      end
    end
  end

  int exp_rr[6]  = '{0, 1, 2, 3, 1, 3};
  int exp_rst[4] = '{0, 1, 2, 3};

  initial begin
    reset = 1'b1; req = '0; req_addr = '0; render_req = 1'b0; render_addr = '0;
    a_req = '0; nr_req = 0; nr_addr = '0; mode = 0; p_render = 50; p_req = 30;
    rec_on = 0; mon_on = 1;
    for (int i = 0; i < NR; i++) a_addr[i] = '0;
    for (int i = 0; i < 4096; i++) rom_mem[i] = bit'($urandom_range(1));
    do_reset();

    // Render only.
    rom_mem[12'h123] = 1'b1;
    nr_req = 1; nr_addr = 12'h123;
    step();
    nr_req = 0;
    repeat (6) step();

    // Round-robin order, then a sparse pattern.
    g_log.delete(); rec_on = 1;
    a_req = 4'b1111;
    for (int i = 0; i < NR; i++) a_addr[i] = AW'(12'h400 + i);
    repeat (8) step();
    a_req = 4'b1010;
    repeat (6) step();
    rec_on = 0;
    check("rr_order_len", g_log.size(), 6);
    for (int i = 0; i < 6 && i < g_log.size(); i++) check("rr_order", g_log[i], exp_rr[i]);

    // Starvation guard.
    starve_run("starve");

    // Back-to-back render/game mix with alternating wall bits.
    rom_mem[12'h0A5] = 1'b1;
    for (int i = 0; i < NR; i++) begin
      a_addr[i] = AW'(12'h100 + i);
      rom_mem[12'h100 + i] = 1'b0;
    end
    a_req = 4'b1111;
    nr_addr = 12'h0A5;
    for (int k = 0; k < 12; k++) begin
      nr_req = (k % 2 == 0);
      step();
    end
    nr_req = 0;
    repeat (3) step();

    // Move rr_ptr off zero, put reads in flight, then reset.
    a_req = 4'b0010; a_addr[1] = 12'h200;
    repeat (3) step();
    nr_req = 1; nr_addr = 12'h0A5;
    step();
    step();
    do_reset();
    g_log.delete(); rec_on = 1;
    a_req = 4'b1111;
    for (int i = 0; i < NR; i++) a_addr[i] = AW'(12'h600 + i);
    repeat (8) step();
    rec_on = 0;
    check("rst_order_len", g_log.size(), 4);
    for (int i = 0; i < 4 && i < g_log.size(); i++) check("rst_order", g_log[i], exp_rst[i]);

    // Drop before grant, then prove the starvation count restarted.
    nr_req = 1; nr_addr = 12'h0F0;
    a_req[2] = 1'b1; a_addr[2] = 12'h777;
    step();
    a_req[2] = 1'b0;
    g_log.delete(); rec_on = 1;
    repeat (10) step();
    rec_on = 0;
    check("drop_no_gnt", g_log.size(), 0);
    starve_run("starve_after_drop");

    // Randomized traffic, moderate then heavy renderer load.
    mode = 1; p_render = 50; p_req = 30;
    repeat (1500) step();
    p_render = 95; p_req = 20;
    repeat (400) step();
    mode = 0; nr_req = 0;
    repeat (40) step();
    check("sb_drained", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
